// File: rtl/pixel_gap_filling.sv
// In-place gap filler: a pixel becomes FILL_VALUE when marked pixels lie within
// GAP positions on both sides of it along the selected axis (X in-row, or Y).
module pixel_gap_filling #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 18,
  parameter int IMAGE_WIDTH = 320,
  parameter int GAP         = 1,
  parameter int FILL_VALUE  = 1
) (
  input  logic                  clk_div_by_two,
  input  logic                  reset,
  input  logic                  pause,
  input  logic                  enable_pixel_gap_filling,
  input  logic                  axis_y,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-1:0] end_address,
  input  logic [DATA_WIDTH-1:0] data_read,
  output logic                  wren,
  output logic [DATA_WIDTH-1:0] data_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  pixel_gap_filling_done
);

  localparam int NUM_ISSUE = 2 * GAP + 1;
  localparam int IDX_W     = 5;
  localparam int COL_W     = $clog2(IMAGE_WIDTH + 8);
  localparam int AW1       = ADDR_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] FILL_WORD   = DATA_WIDTH'(FILL_VALUE);
  localparam logic [COL_W-1:0]      COL_LAST    = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [COL_W-1:0]      COL_WIDTH   = COL_W'(IMAGE_WIDTH);
  localparam logic [IDX_W-1:0]      IDX_COLLECT = IDX_W'(2 * GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_READ, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  logic                  r_axis_y;
  logic [ADDR_WIDTH-1:0] r_start;
  logic [ADDR_WIDTH-1:0] r_end;
  logic [ADDR_WIDTH-1:0] r_p;
  logic [COL_W-1:0]      r_col;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_center;
  logic                  r_neg_hit;
  logic                  r_pos_hit;
  logic                  r_pause_d;
  logic [DATA_WIDTH-1:0] r_hold_data;

  logic [ADDR_WIDTH-1:0] w_issue_addr  [NUM_ISSUE];
  logic                  w_issue_valid [NUM_ISSUE];

  // Issue j: 0 = centre, 1..GAP = negative side, GAP+1..2*GAP = positive side.
  generate
    for (genvar gi = 0; gi < NUM_ISSUE; gi++) begin : g_issue
      if (gi == 0) begin : g_center
        assign w_issue_addr[gi]  = r_p;
        assign w_issue_valid[gi] = 1'b1;
      end else begin : g_side
        localparam int K = (gi <= GAP) ? gi : gi - GAP;
        localparam logic [AW1-1:0]   OFF_X = AW1'(K);
        localparam logic [AW1-1:0]   OFF_Y = AW1'(K * IMAGE_WIDTH);
        localparam logic [COL_W-1:0] K_COL = COL_W'(K);
        logic [AW1-1:0] w_off;
        assign w_off = r_axis_y ? OFF_Y : OFF_X;
        if (gi <= GAP) begin : g_neg
          logic [ADDR_WIDTH-1:0] w_diff;
          assign w_diff            = r_p - w_off[ADDR_WIDTH-1:0];
          assign w_issue_addr[gi]  = w_diff;
          assign w_issue_valid[gi] = ({1'b0, r_p} >= w_off) && (w_diff >= r_start)
                                     && (r_axis_y || (r_col >= K_COL));
        end else begin : g_pos
          logic [AW1-1:0] w_sum;
          assign w_sum             = {1'b0, r_p} + w_off;
          assign w_issue_addr[gi]  = w_sum[ADDR_WIDTH-1:0];
          assign w_issue_valid[gi] = !w_sum[ADDR_WIDTH] && (w_sum[ADDR_WIDTH-1:0] <= r_end)
                                     && (r_axis_y || ((r_col + K_COL) < COL_WIDTH));
        end
      end
    end
  endgenerate

  // Address to issue next (r_idx+1) and attributes of the data arriving now (r_idx-1).
  logic [ADDR_WIDTH-1:0] w_next_addr;
  logic                  w_cap_valid;
  logic                  w_cap_center;
  logic                  w_cap_neg;
  logic                  w_cap_pos;

  always_comb begin
    w_next_addr  = r_p;
    w_cap_valid  = 1'b0;
    w_cap_center = 1'b0;
    w_cap_neg    = 1'b0;
    w_cap_pos    = 1'b0;
    for (int j = 0; j < NUM_ISSUE; j++) begin
      if (r_idx + IDX_W'(1) == IDX_W'(j)) w_next_addr = w_issue_addr[j];
      if (r_idx == IDX_W'(j + 1)) begin
        w_cap_valid  = w_issue_valid[j];
        w_cap_center = (j == 0);
        w_cap_neg    = (j >= 1) && (j <= GAP);
        w_cap_pos    = (j > GAP);
      end
    end
  end

  // The SRAM keeps advancing while we are frozen, so the word that was due at the
  // first paused edge is parked and consumed on the first edge after resuming.
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_marked;
  logic                  w_neg_hit;
  logic                  w_pos_hit;
  logic [DATA_WIDTH-1:0] w_fill_word;

  assign w_data      = r_pause_d ? r_hold_data : data_read;
  assign w_marked    = (w_data == FILL_WORD);
  assign w_neg_hit   = r_neg_hit | (w_cap_neg & w_cap_valid & w_marked);
  assign w_pos_hit   = r_pos_hit | (w_cap_pos & w_cap_valid & w_marked);
  assign w_fill_word = ((r_center == FILL_WORD) || (w_neg_hit && w_pos_hit)) ? FILL_WORD : r_center;

  always_ff @(posedge clk_div_by_two or posedge reset) begin
    if (reset) begin
      r_state                <= S_IDLE;
      r_axis_y               <= 1'b0;
      r_start                <= '0;
      r_end                  <= '0;
      r_p                    <= '0;
      r_col                  <= '0;
      r_idx                  <= '0;
      r_center               <= '0;
      r_neg_hit              <= 1'b0;
      r_pos_hit              <= 1'b0;
      r_pause_d              <= 1'b0;
      r_hold_data            <= '0;
      wren                   <= 1'b0;
      data_write             <= '0;
      address                <= '0;
      pixel_gap_filling_done <= 1'b0;
    end else begin
      r_pause_d <= pause;
      if (pause && !r_pause_d) r_hold_data <= data_read;
      if (!pause) begin
        if (!enable_pixel_gap_filling) begin
          r_state                <= S_IDLE;
          r_idx                  <= '0;
          wren                   <= 1'b0;
          data_write             <= '0;
          address                <= '0;
          pixel_gap_filling_done <= 1'b0;
        end else begin
          unique case (r_state)
            S_IDLE: begin
              r_state                <= S_INIT;
              wren                   <= 1'b0;
              pixel_gap_filling_done <= 1'b0;
            end
            S_INIT: begin
              r_axis_y  <= axis_y;
              r_start   <= start_address;
              r_end     <= end_address;
              r_p       <= start_address;
              r_col     <= '0;
              r_idx     <= '0;
              r_neg_hit <= 1'b0;
              r_pos_hit <= 1'b0;
              wren      <= 1'b0;
              if (end_address < start_address) begin
                r_state                <= S_DONE;
                pixel_gap_filling_done <= 1'b1;
              end else begin
                r_state <= S_READ;
                address <= start_address;
              end
            end
            S_READ: begin
              if (w_cap_center) r_center <= w_data;
              r_neg_hit <= w_neg_hit;
              r_pos_hit <= w_pos_hit;
              if (r_idx == IDX_COLLECT) begin
                r_state    <= S_WRITE;
                wren       <= 1'b1;
                address    <= r_p;
                data_write <= w_fill_word;
              end else begin
                r_idx   <= r_idx + IDX_W'(1);
                address <= w_next_addr;
              end
            end
            S_WRITE: begin
              wren      <= 1'b0;
              r_idx     <= '0;
              r_neg_hit <= 1'b0;
              r_pos_hit <= 1'b0;
              if (r_p == r_end) begin
                r_state                <= S_DONE;
                pixel_gap_filling_done <= 1'b1;
              end else begin
                r_state <= S_READ;
                r_p     <= r_p + ADDR_WIDTH'(1);
                address <= r_p + ADDR_WIDTH'(1);
                r_col   <= (r_col == COL_LAST) ? '0 : r_col + COL_W'(1);
              end
            end
            S_DONE: begin
              wren                   <= 1'b0;
              pixel_gap_filling_done <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_gap_filling.sv
// Bench for pixel_gap_filling: GAP=1 and GAP=2 instances on private SRAM models,
// final memory compared against a pixel-by-pixel reference of the fill rule.
module tb_pixel_gap_filling;

  localparam int W    = 320;
  localparam int MEMN = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, pause;
  logic        en [2];
  logic        ay [2];
  logic [17:0] sa [2];
  logic [17:0] ea [2];
  logic [17:0] addr [2];
  logic [31:0] rd [2];
  logic [31:0] dw [2];
  logic        wr [2];
  logic        dn [2];

  logic [31:0] mem [2][MEMN];
  logic [31:0] stage [MEMN];
  logic [31:0] exp_mem [MEMN];
  logic        load_req;
  int          load_u;

  int checks = 0;
  int errors = 0;

  logic [17:0] alog [$];
  logic        wlog [$];
  int          mon_u = 0;

  pixel_gap_filling #(.GAP(1)) u_dut1 (
    .clk_div_by_two(clk), .reset(rst), .pause(pause),
    .enable_pixel_gap_filling(en[0]), .axis_y(ay[0]),
    .start_address(sa[0]), .end_address(ea[0]), .data_read(rd[0]),
    .wren(wr[0]), .data_write(dw[0]), .address(addr[0]),
    .pixel_gap_filling_done(dn[0]));

  pixel_gap_filling #(.GAP(2)) u_dut2 (
    .clk_div_by_two(clk), .reset(rst), .pause(pause),
    .enable_pixel_gap_filling(en[1]), .axis_y(ay[1]),
    .start_address(sa[1]), .end_address(ea[1]), .data_read(rd[1]),
    .wren(wr[1]), .data_write(dw[1]), .address(addr[1]),
    .pixel_gap_filling_done(dn[1]));

  // SRAM models: one-cycle registered read, write on clock edge, bulk load from stage[].
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (load_req && load_u == u) begin
        for (int a = 0; a < MEMN; a++) mem[u][a] <= stage[a];
      end else if (wr[u] && addr[u] < 18'(MEMN)) begin
        mem[u][addr[u][11:0]] <= dw[u];
      end
      rd[u] <= (addr[u] < 18'(MEMN)) ? mem[u][addr[u][11:0]] : 32'd0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (en[mon_u] === 1'b1) begin
      alog.push_back(addr[mon_u]);
      wlog.push_back(wr[mon_u]);
    end
  end

  task automatic clear_stage();
    for (int a = 0; a < MEMN; a++) stage[a] = 32'd0;
  endtask

  task automatic random_stage();
    int r;
    for (int a = 0; a < MEMN; a++) begin
      r = $urandom_range(0, 9);
      stage[a] = (r < 3) ? 32'd1 : (r == 3) ? $urandom : 32'd0;
    end
  endtask

  task automatic load_mem(input int u);
    load_u   = u;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
    for (int a = 0; a < MEMN; a++) exp_mem[a] = stage[a];
  endtask

  task automatic snapshot_mem(input int u);
    for (int a = 0; a < MEMN; a++) exp_mem[a] = mem[u][a];
  endtask

  // Reference: visit pixels in order, read neighbours from the already-updated image.
  task automatic model_pass(input int s_a, input int e_a, input logic y, input int gap);
    int s, col, q;
    logic neg, pos;
    s = y ? W : 1;
    for (int p = s_a; p <= e_a; p++) begin
      col = p % W;
      neg = 1'b0;
      pos = 1'b0;
      for (int k = 1; k <= gap; k++) begin
        q = p - k * s;
        if (q >= s_a && (y || col - k >= 0) && exp_mem[q] == 32'd1) neg = 1'b1;
        q = p + k * s;
        if (q <= e_a && q < MEMN && (y || col + k < W) && exp_mem[q] == 32'd1) pos = 1'b1;
      end
      if (exp_mem[p] == 32'd1 || (neg && pos)) exp_mem[p] = 32'd1;
    end
  endtask

  function automatic int count_diff(input int u);
    int n = 0;
    for (int a = 0; a < MEMN; a++) if (mem[u][a] !== exp_mem[a]) n++;
    return n;
  endfunction

  function automatic int wren_count();
    int n = 0;
    foreach (wlog[i]) if (wlog[i] === 1'b1) n++;
    return n;
  endfunction

  function automatic int bad_spacing(input int period);
    int n = 0;
    int last = -1;
    foreach (wlog[i]) begin
      if (wlog[i] === 1'b1) begin
        if (last >= 0 && i - last != period) n++;
        last = i;
      end
    end
    return n;
  endfunction

  task automatic run_pass(input int u, input int s_a, input int e_a, input logic y,
                          output int cycles);
    mon_u = u;
    alog.delete();
    wlog.delete();
    ay[u] = y;
    sa[u] = 18'(s_a);
    ea[u] = 18'(e_a);
    en[u] = 1'b1;
    cycles = 0;
    while (dn[u] !== 1'b1 && cycles < 20000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    $display("pass: gap=%0d axis_y=%0d start=%0d end=%0d cycles=%0d writes=%0d",
             u + 1, y, s_a, e_a, cycles, wren_count());
    en[u] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++; if (wr[u] !== 1'b0) begin errors++; $display("FAIL reset_wren u%0d: got %b want 0", u, wr[u]); end
      checks++; if (addr[u] !== 18'd0) begin errors++; $display("FAIL reset_addr u%0d: got %0d want 0", u, addr[u]); end
      checks++; if (dw[u] !== 32'd0) begin errors++; $display("FAIL reset_data u%0d: got %0h want 0", u, dw[u]); end
      checks++; if (dn[u] !== 1'b0) begin errors++; $display("FAIL reset_done u%0d: got %b want 0", u, dn[u]); end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_x_fill();
    int cyc, n;
    clear_stage();
    stage[10] = 32'd1;
    stage[12] = 32'd1;
    load_mem(0);
    model_pass(0, 19, 1'b0, 1);
    run_pass(0, 0, 19, 1'b0, cyc);
    checks++; if (cyc !== 5 * 20 + 2) begin errors++; $display("FAIL x_done_latency: got %0d want %0d", cyc, 5 * 20 + 2); end
    checks++; if (mem[0][11] !== 32'd1) begin errors++; $display("FAIL x_fill_mem11: got %0h want 1", mem[0][11]); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL x_fill_image: %0d words differ, want 0", n); end
    n = wren_count();
    checks++; if (n !== 20) begin errors++; $display("FAIL x_wren_pulses: got %0d want 20", n); end
    n = bad_spacing(5);
    checks++; if (n !== 0) begin errors++; $display("FAIL x_wren_spacing: %0d gaps not 5 cycles", n); end
    checks++;
    if (alog.size() < 61) begin
      errors++; $display("FAIL x_issue_order: log has %0d entries, want >= 61", alog.size());
    end else if (alog[56] !== 18'd11 || alog[57] !== 18'd10 || alog[58] !== 18'd12 ||
                 wlog[60] !== 1'b1 || alog[60] !== 18'd11) begin
      errors++;
      $display("FAIL x_issue_order: got %0d,%0d,%0d write %b@%0d want 11,10,12 write 1@11",
               alog[56], alog[57], alog[58], wlog[60], alog[60]);
    end
  endtask

  task automatic test_row_boundary();
    int cyc, n;
    clear_stage();
    stage[319] = 32'd1;
    stage[321] = 32'd1;
    load_mem(0);
    model_pass(0, 639, 1'b0, 1);
    run_pass(0, 0, 639, 1'b0, cyc);
    checks++; if (mem[0][320] !== 32'd0) begin errors++; $display("FAIL row_bound_mem320: got %0h want 0", mem[0][320]); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL row_bound_image: %0d words differ, want 0", n); end
    checks++; if (cyc !== 5 * 640 + 2) begin errors++; $display("FAIL row_bound_latency: got %0d want %0d", cyc, 5 * 640 + 2); end
  endtask

  task automatic test_y_mode();
    int cyc, n;
    clear_stage();
    stage[320] = 32'd1;
    stage[960] = 32'd1;
    load_mem(0);
    model_pass(320, 1279, 1'b1, 1);
    run_pass(0, 320, 1279, 1'b1, cyc);
    checks++; if (mem[0][640] !== 32'd1) begin errors++; $display("FAIL y_fill_mem640: got %0h want 1", mem[0][640]); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL y_fill_image: %0d words differ, want 0", n); end
    load_mem(0);
    model_pass(320, 959, 1'b0, 1);
    run_pass(0, 320, 959, 1'b0, cyc);
    checks++; if (mem[0][640] !== 32'd0) begin errors++; $display("FAIL y_window_in_x_mem640: got %0h want 0", mem[0][640]); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL y_window_in_x_image: %0d words differ, want 0", n); end
  endtask

  task automatic test_gap2();
    int mark_a [3] = '{18, 19, 19};
    int mark_b [3] = '{21, 18, 21};
    logic [31:0] want [3] = '{32'd1, 32'd0, 32'd1};
    int cyc, n;
    for (int t = 0; t < 3; t++) begin
      clear_stage();
      stage[mark_a[t]] = 32'd1;
      stage[mark_b[t]] = 32'd1;
      load_mem(1);
      model_pass(0, 39, 1'b0, 2);
      run_pass(1, 0, 39, 1'b0, cyc);
      checks++; if (mem[1][20] !== want[t]) begin errors++; $display("FAIL gap2_case%0d_mem20: got %0h want %0h", t, mem[1][20], want[t]); end
      n = count_diff(1);
      checks++; if (n !== 0) begin errors++; $display("FAIL gap2_case%0d_image: %0d words differ, want 0", t, n); end
      checks++; if (cyc !== 7 * 40 + 2) begin errors++; $display("FAIL gap2_case%0d_latency: got %0d want %0d", t, cyc, 7 * 40 + 2); end
      n = bad_spacing(7);
      checks++; if (n !== 0) begin errors++; $display("FAIL gap2_case%0d_spacing: %0d gaps not 7 cycles", t, n); end
    end
  endtask

  task automatic test_pause();
    int cyc0, cyc1, n;
    logic [17:0] a0;
    logic        w0;
    random_stage();
    load_mem(0);
    model_pass(0, 59, 1'b0, 1);
    run_pass(0, 0, 59, 1'b0, cyc0);
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL pause_ref_image: %0d words differ, want 0", n); end
    load_mem(0);
    model_pass(0, 59, 1'b0, 1);
    fork
      run_pass(0, 0, 59, 1'b0, cyc1);
      begin
        repeat (23) @(negedge clk);
        pause = 1'b1;
        a0 = addr[0];
        w0 = wr[0];
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          checks++;
          if (addr[0] !== a0 || wr[0] !== w0) begin
            errors++;
            $display("FAIL pause_frozen_%0d: got addr=%0d wren=%b want addr=%0d wren=%b", i, addr[0], wr[0], a0, w0);
          end
        end
        pause = 1'b0;
      end
    join
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL pause_image: %0d words differ, want 0", n); end
    checks++; if (cyc1 !== cyc0 + 10) begin errors++; $display("FAIL pause_latency: got %0d want %0d", cyc1, cyc0 + 10); end
  endtask

  task automatic test_reset_midpass();
    int n = 0;
    clear_stage();
    load_mem(0);
    ay[0] = 1'b0; sa[0] = 18'd0; ea[0] = 18'd19; en[0] = 1'b1;
    while (wr[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++; if (wr[0] !== 1'b1) begin errors++; $display("FAIL reset_mid_wren_seen: got %b want 1", wr[0]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (wr[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_wren: got %b want 0", wr[0]); end
    checks++; if (addr[0] !== 18'd0) begin errors++; $display("FAIL reset_mid_addr: got %0d want 0", addr[0]); end
    en[0] = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int cyc, n;
    random_stage();
    load_mem(0);
    ay[0] = 1'b0; sa[0] = 18'd320; ea[0] = 18'd419; en[0] = 1'b1;
    repeat (30) @(negedge clk);
    en[0] = 1'b0;
    @(negedge clk);
    checks++; if (wr[0] !== 1'b0) begin errors++; $display("FAIL drop_wren: got %b want 0", wr[0]); end
    checks++; if (addr[0] !== 18'd0) begin errors++; $display("FAIL drop_addr: got %0d want 0", addr[0]); end
    checks++; if (dw[0] !== 32'd0) begin errors++; $display("FAIL drop_data: got %0h want 0", dw[0]); end
    checks++; if (dn[0] !== 1'b0) begin errors++; $display("FAIL drop_done: got %b want 0", dn[0]); end
    snapshot_mem(0);
    model_pass(320, 419, 1'b0, 1);
    run_pass(0, 320, 419, 1'b0, cyc);
    checks++;
    if (alog.size() < 2 || alog[1] !== 18'd320) begin
      errors++; $display("FAIL restart_first_addr: got %0d want 320", (alog.size() < 2) ? -1 : int'(alog[1]));
    end
    checks++; if (cyc !== 5 * 100 + 2) begin errors++; $display("FAIL restart_latency: got %0d want %0d", cyc, 5 * 100 + 2); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL restart_image: %0d words differ, want 0", n); end
  endtask

  task automatic test_empty_window();
    int cyc, n;
    random_stage();
    load_mem(0);
    run_pass(0, 640, 100, 1'b0, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL empty_latency: got %0d want 2", cyc); end
    n = wren_count();
    checks++; if (n !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", n); end
    n = count_diff(0);
    checks++; if (n !== 0) begin errors++; $display("FAIL empty_image: %0d words differ, want 0", n); end
  endtask

  task automatic test_random();
    int u, gap, s_a, e_a, cyc, n;
    logic y;
    for (int it = 0; it < 8; it++) begin
      u   = it % 2;
      gap = u + 1;
      y   = 1'($urandom_range(0, 1));
      s_a = W * $urandom_range(0, 2);
      e_a = s_a + $urandom_range(0, 299);
      random_stage();
      load_mem(u);
      model_pass(s_a, e_a, y, gap);
      run_pass(u, s_a, e_a, y, cyc);
      n = count_diff(u);
      checks++; if (n !== 0) begin errors++; $display("FAIL random%0d_image: %0d words differ, want 0", it, n); end
      checks++;
      if (cyc !== (2 * gap + 3) * (e_a - s_a + 1) + 2) begin
        errors++; $display("FAIL random%0d_latency: got %0d want %0d", it, cyc, (2 * gap + 3) * (e_a - s_a + 1) + 2);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    pause    = 1'b0;
    load_req = 1'b0;
    load_u   = 0;
    for (int u = 0; u < 2; u++) begin
      en[u] = 1'b0; ay[u] = 1'b0; sa[u] = 18'd0; ea[u] = 18'd0;
    end
    test_reset();
    test_x_fill();
    test_row_boundary();
    test_y_mode();
    test_gap2();
    test_pause();
    test_reset_midpass();
    test_enable_drop();
    test_empty_window();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_gap_filling.md
Name: pixel_gap_filling

Overview:
Parametrised successor to the single-pixel X-direction edge filler. It scans a frame-buffer window in place and marks a pixel with FILL_VALUE when marked pixels lie within GAP positions on both sides of it. Axis is selectable: X (stride 1, row-bounded) or Y (stride IMAGE_WIDTH). It sits on the shared frame-buffer SRAM port alongside the other image-processing passes, sequenced by the top-level enable/done scheme.

Parameters:
DATA_WIDTH, 32, pixel word width
ADDR_WIDTH, 18, frame-buffer address width
IMAGE_WIDTH, 320, pixels per row; also the Y-mode stride
GAP, 1, search radius in pixels per side; legal range 1..7
FILL_VALUE, 1, value that counts as marked and is written on fill

Ports:
clk_div_by_two  in  1  pass clock, rising edge
reset  in  1  asynchronous, active-high
pause  in  1  1 = freeze all state and outputs
enable_pixel_gap_filling  in  1  level; 1 = run the pass, 0 = idle/clear
axis_y  in  1  0 = X axis, 1 = Y axis; sampled on start
start_address  in  ADDR_WIDTH  first pixel processed; must be a multiple of IMAGE_WIDTH; sampled on start
end_address  in  ADDR_WIDTH  last pixel processed, inclusive; sampled on start
data_read  in  DATA_WIDTH  SRAM read data, valid the cycle after its address is issued
wren  out  1  SRAM write enable
data_write  out  DATA_WIDTH  SRAM write data
address  out  ADDR_WIDTH  SRAM address
pixel_gap_filling_done  out  1  pass complete; held until enable drops

Behaviour:
- Reset (asynchronous): state IDLE; wren=0, address=0, data_write=0, done=0; all counters 0.
- pause=1: no register changes and all outputs hold. This has priority over everything except reset.
- enable=0 (any state, including mid-pass): next edge goes to IDLE with wren=0, address=0, data_write=0, done=0.
- States: IDLE, INIT, READ, WRITE, DONE.
- IDLE -> INIT when enable=1. INIT latches axis_y, start_address and end_address, sets p=start_address, col=0 and wren=0.
- If end_address < start_address, INIT -> DONE with no writes.
- Per-pixel timing is a fixed 2*GAP+3 cycles:
  - READ issues 2*GAP+1 addresses on consecutive cycles, in this order: p; then p-k*s for k=1..GAP; then p+k*s for k=1..GAP. Here s=1 (X) or IMAGE_WIDTH (Y).
  - Data is captured one cycle after each issue.
  - Then one extra cycle collects the last data.
  - Then WRITE: exactly one cycle with wren=1, address=p, and data_write = FILL_VALUE if (center==FILL_VALUE) or (neg_hit and pos_hit), else center.
- Every pixel is written, unchanged or not.
- neg_hit / pos_hit: any read on that side equals FILL_VALUE.
- Invalid neighbours are still issued, keeping the timing fixed, but their data is ignored and counts as unmarked:
  - address < start_address or > end_address;
  - arithmetic under/overflow of ADDR_WIDTH;
  - in X mode, any neighbour outside the current row (col-k < 0 or col+k >= IMAGE_WIDTH).
- col tracks p mod IMAGE_WIDTH via a wrapping counter; no divider.
- Writes are in place, so a pixel filled earlier counts as marked when later pixels read it.
- After WRITE: if p==end_address -> DONE; else p=p+1, col wraps at IMAGE_WIDTH-1 -> 0, and READ restarts.
- DONE: done=1, wren=0, address holds. Stay in DONE while enable=1; exit only via enable=0.

Test Plan:
- X, GAP=1, row starting at start_address=0: mem[10]=mem[12]=1, mem[11]=0 -> mem[11]=1. Exactly one wren pulse per pixel, spaced 5 cycles apart. done rises 5*(N)+2 cycles after enable, where N = number of pixels.
- X, row boundary, IMAGE_WIDTH=320: mem[319]=1, mem[321]=1, mem[320]=0 -> mem[320] stays 0.
- Y mode: mem[p-320]=mem[p+320]=1, mem[p]=0 -> mem[p]=1. Same window in X mode -> mem[p] stays 0.
- GAP=2, X mode:
  - mem[p-2]=1, mem[p+1]=1 -> mem[p]=1.
  - Only mem[p-1]=mem[p-2]=1 -> mem[p]=0.
  - mem[p-1]=mem[p+1]=1 with mem[p]=0 -> fills p.
- pause held for 10 cycles mid-READ -> address/wren frozen throughout. Final memory is identical to an unpaused run, and done is delayed by exactly 10 cycles.
- reset pulsed while wren=1 -> wren=0 with no clock edge. Dropping enable mid-pass -> IDLE, done=0, outputs 0. Re-enabling -> the pass restarts from start_address.
